string_to_board: RTL and testbench
==================================

Name: string_to_board

Overview:
- Receive-side counterpart of the board printer: consumes the ASCII character stream arriving from the UART receiver and reconstructs the packed 16-cell 2048 board.
- Lets a host load, or replay, a board position by sending text in the same format the printer emits. Extra separator and frame characters are tolerated.
- Sits between the UART RX byte strobe and the game-state register's load port.

Parameters:
- CELL_W, 20, bits per cell in the packed board.
- NUM_CELLS, 16, cells per board, row-major.
- MAX_DIGITS, 6, maximum decimal digits accepted per cell value.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new parse; clears the working buffer and cell index.
- char_in  input  8  received ASCII character.
- char_valid  input  1  char_in is valid this cycle (one-cycle strobe per byte).
- board  output  CELL_W*NUM_CELLS  last completely parsed board; cell k is at [k*CELL_W +: CELL_W], with k = row*4+col.
- board_valid  output  1  one-cycle pulse when board has just been updated.
- busy  output  1  parse in progress (state not IDLE).
- err  output  1  sticky error flag; cleared by start or reset.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, board=0, board_valid=0, busy=0, err=0, working buffer=0, cell index=0, accumulator=0, digit count=0.
- States:
  - IDLE: char_valid ignored. start -> SEEK; clear working buffer, index, accumulator, digit count, err.
  - SEEK (between numbers): digit '0'..'9' -> acc=digit, dcnt=1, go NUM. Any non-digit is discarded, including '|', '-', ' ', CR, LF and letters.
  - NUM: digit -> acc=acc*10+digit, dcnt+1. If dcnt would exceed MAX_DIGITS -> err=1, go IDLE; board unchanged, no pulse. Non-digit -> commit acc[CELL_W-1:0] to working cell[index], index+1, go SEEK. If this commit was the last cell (index==NUM_CELLS-1), go to IDLE instead.
- Final commit, on the same edge: board <= working buffer with the final cell included, board_valid=1 for exactly one cycle, busy=0. The terminating separator is sampled on edge N; board_valid is high during cycle N+1.
- Accumulator width is ceil(log2(10^MAX_DIGITS)) bits (20 for the default). With the default, 999999 fits in CELL_W, so no truncation occurs.
- Leading zeros are legal: "0002" yields 2. A number is committed only by a following non-digit; there is no timeout.
- busy is 1 in SEEK and NUM.
- start while busy: the parse restarts, the working buffer clears, board holds its old value, and no pulse occurs.
- start and char_valid in the same cycle: start wins and that character is dropped.
- char_valid on consecutive cycles must be supported: one character per clock, no back-pressure.
- Reset mid-parse: everything returns to reset values immediately, including board.
- board changes only at a successful completion. Partial parses never leak to the output.
- Characters with bit 7 set count as non-digits.

Test Plan:
- Basic load: start, then send "2 4 8 16 32 64 128 256 512 1024 2048 0 0 2 4 8\n". Required: board_valid pulses once, one cycle after LF; cell0=2, cell9=1024, cell10=2048, cell15=8; busy falls with the pulse; err=0.
- Printer format: send the full printer output for a board with row 1 = 0002|0004|0000|2048, all other cells 0. This includes the "----" lines and "|      |" lines and the score line. Required: cells 4..7 = 2,4,0,2048, all others 0, and exactly one pulse. The score line arrives after completion and is ignored while in IDLE.
- Overflow: start, send "1234567 ". Required: err=1 after the 7th digit, state IDLE, board and board_valid unchanged. A following start clears err.
- Restart: start, send "8 8 8 ", then start again, then 16 x "2 ". Required: all cells=2; cell0..2 are not 8.
- Reset mid-parse: after a completed load, start and send "4 4 ", then pulse rst_n low asynchronously between clock edges. Required: board=0, busy=0, err=0 immediately. A later send of 16 numbers with no start produces no pulse.
- Back-to-back bytes: stream "1,2,...,16," with char_valid held high every cycle. Required: cell k=k+1 and a single board_valid pulse.

Source files
------------

// File: rtl/string_to_board.sv
// Parses decimal text arriving from the UART receiver into a packed 16-cell 2048 board.
// Any non-digit separates numbers; the output board updates only after the last cell is committed.
module string_to_board #(
   parameter int CELL_W     = 20,
   parameter int NUM_CELLS  = 16,
   parameter int MAX_DIGITS = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [7:0]                  char_in,
   input  logic                        char_valid,
   output logic [CELL_W*NUM_CELLS-1:0] board,
   output logic                        board_valid,
   output logic                        busy,
   output logic                        err
);

   localparam int BOARD_W = CELL_W * NUM_CELLS;
   localparam int ACC_W   = $clog2(10 ** MAX_DIGITS);
   localparam int IDX_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
   localparam int DCNT_W  = $clog2(MAX_DIGITS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEEK = 2'd1;
   localparam logic [1:0] ST_NUM  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [BOARD_W-1:0] buf_q,   buf_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [ACC_W-1:0]   acc_q,   acc_d;
   logic [DCNT_W-1:0]  dcnt_q,  dcnt_d;
   logic               valid_q, valid_d;
   logic               busy_q,  busy_d;
   logic               err_q,   err_d;

   logic               is_digit_s;
   logic [ACC_W+3:0]   acc_next_s;
   logic [CELL_W-1:0]  cell_s;

   // Classify the incoming byte and precompute acc*10+digit; bytes with bit 7 set fall outside '0'..'9'.
   always_comb begin
      is_digit_s = (char_in >= 8'h30) && (char_in <= 8'h39);
      acc_next_s = ({4'b0000, acc_q} << 2'd3) + ({4'b0000, acc_q} << 2'd1)
                 + {{ACC_W{1'b0}}, char_in[3:0]};
      cell_s     = CELL_W'(acc_q);
   end

   // Parser next-state logic; start always takes priority over a same-cycle character.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      board_d = board_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      dcnt_d  = dcnt_q;
      err_d   = err_q;
      valid_d = 1'b0;
      if (start) begin
         state_d = ST_SEEK;
         buf_d   = {BOARD_W{1'b0}};
         idx_d   = {IDX_W{1'b0}};
         acc_d   = {ACC_W{1'b0}};
         dcnt_d  = {DCNT_W{1'b0}};
         err_d   = 1'b0;
      end else if (char_valid) begin
         case (state_q)
            ST_SEEK: begin
               if (is_digit_s) begin
                  acc_d   = {{(ACC_W-4){1'b0}}, char_in[3:0]};
                  dcnt_d  = DCNT_W'(1);
                  state_d = ST_NUM;
               end else begin
                  state_d = ST_SEEK;
               end
            end
            ST_NUM: begin
               if (is_digit_s) begin
                  if (dcnt_q == DCNT_W'(MAX_DIGITS)) begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     acc_d  = acc_next_s[ACC_W-1:0];
                     dcnt_d = dcnt_q + DCNT_W'(1);
                  end
               end else begin
                  buf_d[idx_q*CELL_W +: CELL_W] = cell_s;
                  if (idx_q == IDX_W'(NUM_CELLS - 1)) begin
                     // Final cell: publish the buffer including the cell just committed.
                     board_d = buf_d;
                     valid_d = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = ST_SEEK;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         buf_q   <= {BOARD_W{1'b0}};
         board_q <= {BOARD_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         acc_q   <= {ACC_W{1'b0}};
         dcnt_q  <= {DCNT_W{1'b0}};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         board_q <= board_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         dcnt_q  <= dcnt_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign board       = board_q;
   assign board_valid = valid_q;
   assign busy        = busy_q;
   assign err         = err_q;

endmodule

// File: tb/tb_string_to_board.sv
// Directed bench for string_to_board: stimulus pushes expected boards, a monitor pops them on each pulse.
module tb_string_to_board;

   localparam int CW = 20;
   localparam int NC = 16;
   localparam int BW = CW * NC;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    char_in = 8'h00;
   logic          char_valid = 1'b0;
   logic [BW-1:0] board;
   logic          board_valid;
   logic          busy;
   logic          err;

   int total = 0;
   int bad   = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] last_board = '0;

   string_to_board #(.CELL_W(CW), .NUM_CELLS(NC), .MAX_DIGITS(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .char_in(char_in),
      .char_valid(char_valid), .board(board), .board_valid(board_valid),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pulse must match the oldest queued board, and busy must already be low.
   initial begin
      logic [BW-1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (board_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse: got board %0h expected no pulse", board);
            end else begin
               e = exp_q.pop_front();
               total--;
               chk("board_on_pulse", board, e);
            end
            chk("busy_on_pulse", {{(BW-1){1'b0}}, busy}, {BW{1'b0}});
         end
      end
   end

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         char_in    = s[i];
         char_valid = 1'b1;
      end
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic push_board(input int v[16]);
      logic [BW-1:0] e;
      e = '0;
      for (int k = 0; k < NC; k++) e[k*CW +: CW] = v[k][CW-1:0];
      exp_q.push_back(e);
      last_board = e;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: got %0d pending boards expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      string s;
      int v[16];

      // Reset state
      #8;
      chk("reset_board", board, '0);
      chk("reset_valid", {{(BW-1){1'b0}}, board_valid}, '0);
      chk("reset_busy",  {{(BW-1){1'b0}}, busy}, '0);
      chk("reset_err",   {{(BW-1){1'b0}}, err}, '0);
      #4 rst_n = 1'b1;

      // Basic load
      v = '{2, 4, 8, 16, 32, 64, 128, 256, 512, 1024, 2048, 0, 0, 2, 4, 8};
      push_board(v);
      do_start();
      #3 chk("busy_after_start", {{(BW-1){1'b0}}, busy}, {{(BW-1){1'b0}}, 1'b1});
      send("2 4 8 16 32 64 128 256 512 1024 2048 0 0 2 4 8\n");
      wait_drain("basic");
      chk("basic_err", {{(BW-1){1'b0}}, err}, '0);
      chk("basic_cell9", {{(BW-CW){1'b0}}, board[9*CW +: CW]}, 320'd1024);

      // Printer format with frame lines, blank lines and a trailing score line
      v = '{0, 0, 0, 0, 2, 4, 0, 2048, 0, 0, 0, 0, 0, 0, 0, 0};
      push_board(v);
      s = "";
      for (int r = 0; r < 4; r++) begin
         s = {s, "+------+------+------+------+\r\n", "|      |      |      |      |\r\n"};
         if (r == 1) s = {s, "|  0002|  0004|  0000|  2048|\r\n"};
         else        s = {s, "|  0000|  0000|  0000|  0000|\r\n"};
         s = {s, "|      |      |      |      |\r\n"};
      end
      s = {s, "+------+------+------+------+\r\nScore: 2054\r\n"};
      do_start();
      send(s);
      wait_drain("printer");

      // Overflow on the seventh digit
      do_start();
      send("1234567 ");
      #3;
      chk("ovf_err",   {{(BW-1){1'b0}}, err}, {{(BW-1){1'b0}}, 1'b1});
      chk("ovf_busy",  {{(BW-1){1'b0}}, busy}, '0);
      chk("ovf_board", board, last_board);
      do_start();
      #3 chk("ovf_err_cleared", {{(BW-1){1'b0}}, err}, '0);

      // Restart mid-parse
      for (int k = 0; k < NC; k++) v[k] = 2;
      push_board(v);
      do_start();
      send("8 8 8 ");
      do_start();
      s = "";
      for (int k = 0; k < NC; k++) s = {s, "2 "};
      send(s);
      wait_drain("restart");

      // Asynchronous reset mid-parse, then digits without start must not load anything
      do_start();
      send("4 4 ");
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_board", board, '0);
      chk("rst_busy",  {{(BW-1){1'b0}}, busy}, '0);
      chk("rst_err",   {{(BW-1){1'b0}}, err}, '0);
      #2 rst_n = 1'b1;
      send(s);
      repeat (4) @(posedge clk);
      #3;
      chk("nostart_board", board, '0);
      chk("nostart_busy",  {{(BW-1){1'b0}}, busy}, '0);

      // Back-to-back characters, values 1..16
      for (int k = 0; k < NC; k++) v[k] = k + 1;
      push_board(v);
      s = "";
      for (int k = 1; k <= NC; k++) s = {s, $sformatf("%0d,", k)};
      do_start();
      send(s);
      wait_drain("b2b");
      chk("b2b_cell15", {{(BW-CW){1'b0}}, board[15*CW +: CW]}, 320'd16);

      // Six digits is the legal maximum
      for (int k = 0; k < NC; k++) v[k] = (k == 0) ? 999999 : 0;
      push_board(v);
      do_start();
      send("999999 0 0 0 0 0 0 0 0 0 0 0 0 0 0 000000\n");
      wait_drain("maxdig");
      chk("maxdig_err", {{(BW-1){1'b0}}, err}, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
